dmem_responder: RTL and testbench

//  Data-memory responder: the target end of the MEM-stage load/store interface.

---
 rtl/riscv_mem_pkg.sv | 48 ++++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared MEM-stage definitions: access sizes,
// responder FSM states and size helpers.
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_D  = 3'b011,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101,
    MEM_WU = 3'b110
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  function automatic logic [3:0] size_bytes(
    input logic [2:0] size
  );
    logic [3:0] n;
    case (size[1:0])
      2'b00:   n = 4'd1;
      2'b01:   n = 4'd2;
      2'b10:   n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] size,
    input logic [2:0] lane
  );
    logic m;
    case (size[1:0])
      2'b01:   m = lane[0];
      2'b10:   m = |lane[1:0];
      2'b11:   m = |lane;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data SRAM, 64-bit words,
// byte-enable write and registered read.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // Byte-masked write or registered read of one word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 8; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one MEM request,
// waits LATENCY cycles, then acks with load/err.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_load,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [2:0]  mem_size,
  output logic        mem_busy,
  output logic        data_ack,
  output logic [63:0] data_rdata,
  output logic        data_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, last_wait;

  logic        r_load;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  r_size;

  logic [2:0]  lane;
  logic        err;
  logic [7:0]  be;
  logic [63:0] wdata_sh;
  logic [63:0] arr_rdata;
  logic [63:0] ld_sh;
  logic [63:0] ld_ext;

  // FSM state and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: accept in IDLE, count in WAIT
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    last_wait = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_req) begin
          accept    = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (cnt == 4'(LATENCY)) begin
          last_wait = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, loaded on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
    end else if (accept) begin
      r_load  <= mem_load;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_size  <= mem_size;
    end
  end

  // Error detection and store lane steering
  always_comb begin
    lane = r_addr[2:0];
    err  = is_misaligned(r_size, lane)
         | (|r_addr[63:AW+3])
         | (r_size == 3'b111)
         | (!r_load && r_size[2]);
    be = 8'((9'd1 << size_bytes(r_size)) - 9'd1) << lane;
    wdata_sh = r_wdata << {lane, 3'b000};
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (last_wait),
    .we    (!r_load && !err),
    .be    (be),
    .idx   (r_addr[3 +: AW]),
    .wdata (wdata_sh),
    .rdata (arr_rdata)
  );

  // Load lane select and sign/zero extension
  always_comb begin
    ld_sh  = arr_rdata >> {lane, 3'b000};
    ld_ext = ld_sh;
    unique case (r_size)
      MEM_B:   ld_ext = {{56{ld_sh[7]}}, ld_sh[7:0]};
      MEM_H:   ld_ext = {{48{ld_sh[15]}}, ld_sh[15:0]};
      MEM_W:   ld_ext = {{32{ld_sh[31]}}, ld_sh[31:0]};
      MEM_BU:  ld_ext = {56'd0, ld_sh[7:0]};
      MEM_HU:  ld_ext = {48'd0, ld_sh[15:0]};
      MEM_WU:  ld_ext = {32'd0, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  // Response outputs, live only in RESP
  always_comb begin
    mem_busy   = (state != IDLE);
    data_ack   = (state == RESP);
    data_err   = data_ack && err;
    data_rdata = '0;
    if (data_ack && r_load && !err) data_rdata = ld_ext;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder:
// latency, load/store, errors, abort, back-to-back.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_req, mem_load;
  logic [63:0] mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_busy, data_ack, data_err;
  logic [63:0] data_rdata;

  logic        b_req, b_load;
  logic [63:0] b_addr, b_wdata;
  logic [2:0]  b_size;
  logic        b_busy, b_ack, b_err;
  logic [63:0] b_rdata;

  int passes = 0;
  int total  = 0;

  logic [63:0] r_rdata;
  logic        r_err;
  int          r_lat;

  dmem_responder #(
    .DEPTH   (1024),
    .LATENCY (2)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_load   (mem_load),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_size   (mem_size),
    .mem_busy   (mem_busy),
    .data_ack   (data_ack),
    .data_rdata (data_rdata),
    .data_err   (data_err)
  );

  dmem_responder #(
    .DEPTH   (1024),
    .LATENCY (0)
  ) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (b_req),
    .mem_load   (b_load),
    .mem_addr   (b_addr),
    .mem_wdata  (b_wdata),
    .mem_size   (b_size),
    .mem_busy   (b_busy),
    .data_ack   (b_ack),
    .data_rdata (b_rdata),
    .data_err   (b_err)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic do_req(
    input logic        ld,
    input logic [63:0] a,
    input logic [63:0] wd,
    input logic [2:0]  sz
  );
    int n;
    bit got;
    mem_load  = ld;
    mem_addr  = a;
    mem_wdata = wd;
    mem_size  = sz;
    mem_req   = 1'b1;
    n   = 0;
    got = 1'b0;
    r_rdata = 'x;
    r_err   = 1'bx;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (data_ack) begin
        got     = 1'b1;
        r_rdata = data_rdata;
        r_err   = data_err;
      end
    end
    mem_req = 1'b0;
    r_lat   = n - 1;
    chk("ack_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    chk("post_ack", 64'(data_ack), 64'd0);
    chk("post_rdata", data_rdata, 64'd0);
    chk("post_err", 64'(data_err), 64'd0);
    chk("post_busy", 64'(mem_busy), 64'd0);
  endtask

  function automatic logic [63:0] pat(input int k);
    return {32'hC0DE_0000 + 32'(k), 32'h1234_5678 ^ 32'(k)};
  endfunction

  initial begin
    reset     = 1'b0;
    mem_req   = 1'b1;
    mem_load  = 1'b0;
    mem_addr  = 64'h0;
    mem_wdata = 64'h0;
    mem_size  = 3'b011;
    b_req     = 1'b0;
    b_load    = 1'b0;
    b_addr    = 64'h0;
    b_wdata   = 64'h0;
    b_size    = 3'b011;

    // reset held with request pending
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_busy", 64'(mem_busy), 64'd0);
      chk("rst_ack", 64'(data_ack), 64'd0);
    end
    chk("rst_rdata", data_rdata, 64'd0);
    chk("rst_err", 64'(data_err), 64'd0);
    reset = 1'b1;
    do_req(1'b0, 64'h0, 64'hA5A5_0000_5A5A_FFFF, 3'b011);
    chk("latency", 64'(r_lat), 64'd3);
    chk("sd0_err", 64'(r_err), 64'd0);

    // SD then LD
    do_req(1'b0, 64'h40, 64'h1122_3344_5566_7788, 3'b011);
    chk("sd_err", 64'(r_err), 64'd0);
    chk("sd_rdata", r_rdata, 64'd0);
    do_req(1'b1, 64'h40, 64'h0, 3'b011);
    chk("ld_rdata", r_rdata, 64'h1122_3344_5566_7788);
    chk("ld_err", 64'(r_err), 64'd0);

    // byte store and extension
    do_req(1'b0, 64'h41, 64'h80, 3'b000);
    chk("sb_err", 64'(r_err), 64'd0);
    do_req(1'b1, 64'h41, 64'h0, 3'b000);
    chk("lb", r_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b1, 64'h41, 64'h0, 3'b100);
    chk("lbu", r_rdata, 64'h80);
    do_req(1'b1, 64'h40, 64'h0, 3'b011);
    chk("ld_merge", r_rdata, 64'h1122_3344_5566_8088);

    // errors leave the array untouched
    do_req(1'b1, 64'h42, 64'h0, 3'b010);
    chk("lw_mis_err", 64'(r_err), 64'd1);
    chk("lw_mis_rd", r_rdata, 64'd0);
    do_req(1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011);
    chk("sd_oor_err", 64'(r_err), 64'd1);
    chk("sd_oor_rd", r_rdata, 64'd0);
    do_req(1'b1, 64'h0, 64'h0, 3'b011);
    chk("oor_chk0", r_rdata, 64'hA5A5_0000_5A5A_FFFF);
    do_req(1'b0, 64'h2040, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011);
    chk("sd_oor2_err", 64'(r_err), 64'd1);
    do_req(1'b0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111);
    chk("sz7_err", 64'(r_err), 64'd1);
    chk("sz7_rd", r_rdata, 64'd0);
    do_req(1'b0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100);
    chk("sbu_err", 64'(r_err), 64'd1);
    do_req(1'b1, 64'h40, 64'h0, 3'b011);
    chk("err_chk40", r_rdata, 64'h1122_3344_5566_8088);

    // reset during WAIT aborts a store
    do_req(1'b0, 64'h80, 64'h0123_4567_89AB_CDEF, 3'b011);
    mem_load  = 1'b0;
    mem_addr  = 64'h80;
    mem_wdata = 64'hDEAD;
    mem_size  = 3'b011;
    mem_req   = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(mem_busy), 64'd1);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("abort_busy0", 64'(mem_busy), 64'd0);
    chk("abort_ack0", 64'(data_ack), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("abort_noack", 64'(data_ack), 64'd0);
    end
    do_req(1'b1, 64'h80, 64'h0, 3'b011);
    chk("abort_old", r_rdata, 64'h0123_4567_89AB_CDEF);

    // back-to-back on the zero-latency instance
    b_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_load  = k[0];
      b_addr  = 64'h200 + 64'(8 * (k / 2));
      b_wdata = k[0] ? 64'h0 : pat(k);
      b_size  = 3'b011;
      @(posedge clk);
      #1;
      chk("b2b_busy_a", 64'(b_busy), 64'd1);
      chk("b2b_ack_a", 64'(b_ack), 64'd0);
      @(posedge clk);
      #1;
      chk("b2b_busy_b", 64'(b_busy), 64'd1);
      chk("b2b_ack_b", 64'(b_ack), 64'd1);
      chk("b2b_err", 64'(b_err), 64'd0);
      chk("b2b_rdata", b_rdata, k[0] ? pat(k - 1) : 64'd0);
      @(posedge clk);
      #1;
      chk("b2b_busy_c", 64'(b_busy), 64'd0);
      chk("b2b_ack_c", 64'(b_ack), 64'd0);
    end
    b_req = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_idle", 64'(b_busy), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
